// File: rtl/discrete_gated_vco_voice_pkg.sv
// Shared types and arithmetic helpers for the discrete-sound voice blocks.
// Helpers work in 32-bit signed math, wide enough for SIGNAL_WIDTH+8 products.
package discrete_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        SUSTAIN,
        RELEASE
    } env_state_t;

    // Envelope steps never stall: a zero shift result still moves by one.
    function automatic int at_least_one(input int step);
        return (step < 1) ? 1 : step;
    endfunction

    function automatic int sat_signed(input int x, input int width);
        int hi;
        int lo;
        hi = (1 << (width - 1)) - 1;
        lo = -(1 << (width - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        return x;
    endfunction

    // Gain in quarters; >>> on a signed int floors toward minus infinity.
    function automatic int q2_gain(input int x, input int gain_q2);
        return (x * gain_q2) >>> 2;
    endfunction

endpackage

// File: rtl/discrete_gated_vco_voice_envelope.sv
// Attack/sustain/release envelope generator advancing once per audio strobe.
// A gate transition always takes priority over reaching the ceiling or floor.
module discrete_ar_envelope
    import discrete_pkg::*;
#(
    parameter int SIGNAL_WIDTH    = 16,
    parameter int ENV_MAX         = 6827,
    parameter int ATTACK_SHIFT    = 4,
    parameter int DECAY_SHIFT     = 8,
    parameter bit GATE_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    I_RSTn,
    input  logic                    audio_clk_en,
    input  logic                    gate,
    output logic [SIGNAL_WIDTH-1:0] env,
    output logic                    busy,
    output logic                    trigger_pulse
);

    env_state_t state;
    logic       g;
    int         env_i;
    int         attack_val;
    int         release_val;

    assign g             = GATE_ACTIVE_LOW ? ~gate : gate;
    assign busy          = (state != IDLE);
    assign trigger_pulse = audio_clk_en && (state == IDLE) && g;

    // NOTE: every always_comb output is assigned before any condition, so no latch can form.
    always_comb begin
        env_i       = int'(env);
        attack_val  = env_i + at_least_one((ENV_MAX - env_i) >>> ATTACK_SHIFT);
        release_val = env_i - at_least_one(env_i >>> DECAY_SHIFT);
        if (attack_val > ENV_MAX)
            attack_val = ENV_MAX;
        if (release_val < 0)
            release_val = 0;
    end

    // NOTE: state registers use <= so every branch reads the pre-edge values.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state <= IDLE;
            env   <= '0;
        end else if (audio_clk_en) begin
            unique case (state)
                IDLE: begin
                    if (g) begin
                        state <= ATTACK;
                        env   <= SIGNAL_WIDTH'(attack_val);
                    end else begin
                        env <= '0;
                    end
                end
                ATTACK: begin
                    if (!g) begin
                        state <= RELEASE;
                        env   <= SIGNAL_WIDTH'(release_val);
                    end else begin
                        env <= SIGNAL_WIDTH'(attack_val);
                        if (attack_val == ENV_MAX)
                            state <= SUSTAIN;
                    end
                end
                SUSTAIN: begin
                    if (!g) begin
                        state <= RELEASE;
                        env   <= SIGNAL_WIDTH'(release_val);
                    end else begin
                        env <= SIGNAL_WIDTH'(ENV_MAX);
                    end
                end
                RELEASE: begin
                    if (g) begin
                        state <= ATTACK;
                        env   <= SIGNAL_WIDTH'(attack_val);
                    end else begin
                        env <= SIGNAL_WIDTH'(release_val);
                        if (release_val == 0)
                            state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    env   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/discrete_gated_vco_voice.sv
// Gated tone voice: square LFO -> phase-accumulator VCO -> AR envelope -> asymmetric gain.
// Everything advances only on audio_clk_en; out lags env_out by one strobe.
module discrete_gated_vco_voice
    import discrete_pkg::*;
#(
    parameter int CLOCK_RATE      = 1000000,
    parameter int SAMPLE_RATE     = 48000,
    parameter int SIGNAL_WIDTH    = 16,
    parameter int PHASE_W         = 24,
    parameter int VCO_BASE_INC    = 104858,
    parameter int VCO_MOD_GAIN    = 0,
    parameter int VCO_DUTY        = 2**23,
    parameter int LFO_HALF_PERIOD = 240,
    parameter int LFO_AMPLITUDE   = 2000,
    parameter int ENV_MAX         = 6827,
    parameter int ATTACK_SHIFT    = 4,
    parameter int DECAY_SHIFT     = 8,
    parameter bit GATE_ACTIVE_LOW = 1'b0,
    parameter bit SYNC_ON_TRIGGER = 1'b1,
    parameter int POS_GAIN_Q2     = 6,
    parameter int NEG_GAIN_Q2     = 3
) (
    input  logic                           clk,
    input  logic                           I_RSTn,
    input  logic                           audio_clk_en,
    input  logic                           gate,
    output logic signed [SIGNAL_WIDTH-1:0] out,
    output logic signed [SIGNAL_WIDTH-1:0] env_out,
    output logic                           busy
);

    localparam int MAX_INC = 2**(PHASE_W - 1);

    if (SAMPLE_RATE <= 0 || SAMPLE_RATE > CLOCK_RATE || PHASE_W > 31 || SIGNAL_WIDTH > 23) begin : g_param_check
        $error("discrete_gated_vco_voice: unsupported rate or width parameters");
    end

    logic [SIGNAL_WIDTH-1:0] env;
    logic                    trigger_pulse;
    logic [PHASE_W-1:0]      phase;
    logic [31:0]             lfo_cnt;
    logic                    lfo_level;
    logic                    vco_high;
    int                      lfo_val;
    int                      inc;
    int                      bipolar;
    int                      scaled;

    discrete_ar_envelope #(
        .SIGNAL_WIDTH    (SIGNAL_WIDTH),
        .ENV_MAX         (ENV_MAX),
        .ATTACK_SHIFT    (ATTACK_SHIFT),
        .DECAY_SHIFT     (DECAY_SHIFT),
        .GATE_ACTIVE_LOW (GATE_ACTIVE_LOW)
    ) u_envelope (
        .clk           (clk),
        .I_RSTn        (I_RSTn),
        .audio_clk_en  (audio_clk_en),
        .gate          (gate),
        .env           (env),
        .busy          (busy),
        .trigger_pulse (trigger_pulse)
    );

    assign env_out  = $signed(env);
    assign vco_high = (phase < PHASE_W'(VCO_DUTY));

    always_comb begin
        lfo_val = (LFO_HALF_PERIOD == 0) ? 0 : (lfo_level ? LFO_AMPLITUDE : -LFO_AMPLITUDE);
        inc     = VCO_BASE_INC + ((lfo_val * VCO_MOD_GAIN) >>> 8);
        if (inc < 1)
            inc = 1;
        else if (inc > MAX_INC)
            inc = MAX_INC;
        // Sample is built from the envelope and phase as they stood before this strobe.
        bipolar = vco_high ? int'(env) : -int'(env);
        scaled  = q2_gain(bipolar, (bipolar > 0) ? POS_GAIN_Q2 : NEG_GAIN_Q2);
    end

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            phase     <= '0;
            lfo_cnt   <= '0;
            lfo_level <= 1'b0;
            out       <= '0;
        end else if (audio_clk_en) begin
            out <= SIGNAL_WIDTH'(sat_signed(scaled, SIGNAL_WIDTH));
            if (SYNC_ON_TRIGGER && trigger_pulse) begin
                phase     <= '0;
                lfo_cnt   <= '0;
                lfo_level <= 1'b0;
            end else begin
                phase <= phase + PHASE_W'(inc);
                if (LFO_HALF_PERIOD != 0) begin
                    if (lfo_cnt == 32'(LFO_HALF_PERIOD - 1)) begin
                        lfo_cnt   <= '0;
                        lfo_level <= ~lfo_level;
                    end else begin
                        lfo_cnt <= lfo_cnt + 32'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_discrete_gated_vco_voice.sv
// Directed bench for discrete_gated_vco_voice: default voice plus a high-ceiling
// copy that exercises output saturation, both driven by the same gate/strobe.
module tb_discrete_gated_vco_voice;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               gate;
    logic signed [15:0] out;
    logic signed [15:0] env_out;
    logic               busy;
    logic signed [15:0] out_sat;
    logic signed [15:0] env_sat;
    logic               busy_sat;

    int total = 0;
    int bad   = 0;

    discrete_gated_vco_voice dut (
        .clk          (clk),
        .I_RSTn       (rst_n),
        .audio_clk_en (en),
        .gate         (gate),
        .out          (out),
        .env_out      (env_out),
        .busy         (busy)
    );

    discrete_gated_vco_voice #(.ENV_MAX(30000)) dut_sat (
        .clk          (clk),
        .I_RSTn       (rst_n),
        .audio_clk_en (en),
        .gate         (gate),
        .out          (out_sat),
        .env_out      (env_sat),
        .busy         (busy_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One strobed clock; outputs are sampled on the falling edge after it.
    task automatic pulse();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    initial begin
        int hi_cnt;
        int lo_cnt;
        int other_cnt;
        int sat_max;
        int sat_min;

        en    = 1'b0;
        gate  = 1'b1;
        rst_n = 1'b0;

        // Reset held with gate high and strobes running.
        for (int i = 0; i < 3; i++) begin
            pulse();
            check("rst_out", out, 0);
            check("rst_env", env_out, 0);
            check("rst_busy", busy, 0);
        end
        gate = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        pulse();
        check("idle_env", env_out, 0);
        check("idle_busy", busy, 0);

        // Attack from zero: 6827>>4 = 426, then 426 + (6401>>4) = 826.
        gate = 1'b1;
        pulse();
        check("att1_env", env_out, 426);
        check("att1_busy", busy, 1);
        check("att1_sat_env", env_sat, 1875);
        pulse();
        check("att2_env", env_out, 826);
        check("att2_out", out, 639);

        // Gate glitches between strobes are invisible: 826 + (6001>>4) = 1201.
        gate = 1'b0;
        @(negedge clk);
        @(negedge clk);
        gate = 1'b1;
        pulse();
        check("gating_env", env_out, 1201);

        for (int i = 0; i < 600 && !(env_out == 16'sd6827 && env_sat == 16'sd30000); i++)
            pulse();
        check("sustain_env", env_out, 6827);
        check("sustain_busy", busy, 1);
        check("sustain_sat_env", env_sat, 30000);

        // Sustained tone: ~160-sample period, 6827*6/4 = 10240 and floor(-6827*3/4) = -5121.
        pulse();
        hi_cnt    = 0;
        lo_cnt    = 0;
        other_cnt = 0;
        sat_max   = -100000;
        sat_min   = 100000;
        for (int i = 0; i < 320; i++) begin
            pulse();
            if (out == 16'sd10240)
                hi_cnt++;
            else if (out == -16'sd5121)
                lo_cnt++;
            else
                other_cnt++;
            if (int'(out_sat) > sat_max)
                sat_max = int'(out_sat);
            if (int'(out_sat) < sat_min)
                sat_min = int'(out_sat);
        end
        check("pitch_hi_count_ok", (hi_cnt >= 159 && hi_cnt <= 161) ? 1 : 0, 1);
        check("pitch_lo_count_ok", (lo_cnt >= 159 && lo_cnt <= 161) ? 1 : 0, 1);
        check("pitch_other", other_cnt, 0);
        check("sat_pos", sat_max, 32767);
        check("sat_neg", sat_min, -22500);

        // Release then retrigger from the current level without phase sync.
        gate = 1'b0;
        pulse();
        check("rel1_env", env_out, 6801);
        pulse();
        check("rel2_env", env_out, 6775);
        gate = 1'b1;
        pulse();
        check("retrig1_env", env_out, 6778);
        check("retrig_phase_kept", (dut.phase != 0) ? 1 : 0, 1);
        pulse();
        check("retrig2_env", env_out, 6781);
        check("retrig_busy", busy, 1);

        gate = 1'b0;
        for (int i = 0; i < 3000 && busy; i++)
            pulse();
        check("release_done_env", env_out, 0);
        check("release_done_busy", busy, 0);

        // Asynchronous reset in the middle of an attack.
        gate = 1'b1;
        for (int i = 0; i < 3; i++)
            pulse();
        check("pre_arst_busy", busy, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out", out, 0);
        check("arst_env", env_out, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse();
        check("post_arst_env", env_out, 426);
        check("post_arst_out", out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
